// File: rtl/tangcart_pkg.sv
// Shared constants for the TangNano MSX cartridge: page/port decode values and ROM geometry.
package tangcart_pkg;

    localparam logic [1:0] ROM_PAGE  = 2'b01;
    localparam logic [7:0] LED_PORT  = 8'h10;
    localparam int         ROM_DEPTH = 256;
    localparam int         ROM_AW    = 8;
    localparam int         ROM_DW    = 8;

    // Bit positions of the control strobes inside the synchronizer vectors.
    localparam int SYNC_W   = 5;
    localparam int S_SLTSL  = 4;
    localparam int S_MERQ   = 3;
    localparam int S_IORQ   = 2;
    localparam int S_WR     = 1;
    localparam int S_RD     = 0;

endpackage

// File: rtl/tangcart_rom.sv
// 256x8 combinational ROM holding the cartridge image ("AB" header, INIT=4010h, JR $ loop).
module tangcart_rom
    import tangcart_pkg::*;
(
    input  logic [ROM_AW-1:0] address,
    output logic [ROM_DW-1:0] rdata
);

    always_comb begin
        rdata = 8'hFF;
        case (address)
            8'h00: rdata = 8'h41;
            8'h01: rdata = 8'h42;
            8'h02: rdata = 8'h10;
            8'h03: rdata = 8'h40;
            8'h10: rdata = 8'h18;
            8'h11: rdata = 8'hFE;
            default: rdata = (address < 8'h10) ? 8'h00 : 8'hFF;
        endcase
    end

endmodule

// File: rtl/tangcart_msx_top.sv
// MSX slot decoder serving the 256-byte ROM in page 1. Optional LED I/O port
// at 10h is enabled by defining TANGCART_LED_PORT_EN.
module tangcart_msx_top
    import tangcart_pkg::*;
(
    input  logic        tclock,
    input  logic        n_treset,
    input  logic        n_tsltsl,
    input  logic        n_tmerq,
    input  logic        n_tiorq,
    input  logic        n_twr,
    input  logic        n_trd,
    input  logic [15:0] ta,
    inout  wire  [7:0]  td,
    output logic        tdir,
    output logic        tsnd,
    output logic [5:0]  n_led,
    input  logic [1:0]  button,
    input  logic [6:0]  dip_sw,
    output logic        twait,
    output logic        tint,
    output logic        midi_out,
    input  logic        midi_in
);

    logic [SYNC_W-1:0] sync1_q, sync1_d;
    logic [SYNC_W-1:0] sync2_q, sync2_d;
    logic [15:0]       ta_q, ta_d;
    logic [7:0]        td_q, td_d;
    logic              tdir_q, tdir_d;
    logic [7:0]        data_q, data_d;
    logic [ROM_DW-1:0] rom_rdata;
    logic              rom_req;

    tangcart_rom u_rom (
        .address (ta_q[ROM_AW-1:0]),
        .rdata   (rom_rdata)
    );

    always_comb begin
        sync1_d = {n_tsltsl, n_tmerq, n_tiorq, n_twr, n_trd};
        sync2_d = sync1_q;
        ta_d    = ta;
        td_d    = td;
        rom_req = !sync2_q[S_SLTSL] && !sync2_q[S_MERQ] && !sync2_q[S_RD]
                  && (ta_q[15:14] == ROM_PAGE);
        tdir_d  = rom_req;
        // Keep tracking the address while the read is held so a mid-read change is served.
        data_d  = rom_req ? rom_rdata : data_q;
    end

    always_ff @(posedge tclock) begin
        if (!n_treset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            ta_q    <= '0;
            td_q    <= '0;
            tdir_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            ta_q    <= ta_d;
            td_q    <= td_d;
            tdir_q  <= tdir_d;
            data_q  <= data_d;
        end
    end

    assign td   = tdir_q ? data_q : 8'hzz;
    assign tdir = tdir_q;

`ifdef TANGCART_LED_PORT_EN
    logic       io_wr;
    logic       io_wr_q, io_wr_d;
    logic [5:0] led_q, led_d;

    always_comb begin
        io_wr   = !sync2_q[S_IORQ] && !sync2_q[S_WR];
        io_wr_d = io_wr;
        led_d   = led_q;
        // Latch only on the assertion edge so a long write strobe loads once.
        if (io_wr && !io_wr_q && (ta_q[7:0] == LED_PORT))
            led_d = ~td_q[5:0];
    end

    always_ff @(posedge tclock) begin
        if (!n_treset) begin
            io_wr_q <= 1'b0;
            led_q   <= 6'b111111;
        end else begin
            io_wr_q <= io_wr_d;
            led_q   <= led_d;
        end
    end

    assign n_led = led_q;
`else
    assign n_led = {5'b11111, ~tdir_q};
`endif

    assign tsnd     = 1'b0;
    assign twait    = 1'b0;
    assign tint     = 1'b0;
    assign midi_out = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{button, dip_sw, midi_in, ta_q, td_q, sync2_q};

endmodule

// File: tb/tb_tangcart_msx_top.sv
// Directed bench for tangcart_msx_top: ROM reads, decode boundaries, reset mid-read, LED port.
module tb_tangcart_msx_top;

    logic        tclock = 1'b0;
    logic        n_treset, n_tsltsl, n_tmerq, n_tiorq, n_twr, n_trd;
    logic [15:0] ta;
    wire  [7:0]  td;
    logic        tdir, tsnd, twait, tint, midi_out, midi_in;
    logic [5:0]  n_led;
    logic [1:0]  button;
    logic [6:0]  dip_sw;
    logic        tb_drv;
    logic [7:0]  tb_data;

    int tests = 0;
    int fails = 0;

    always #5 tclock = ~tclock;

    assign td = tb_drv ? tb_data : 8'hzz;

    tangcart_msx_top dut (
        .tclock   (tclock),
        .n_treset (n_treset),
        .n_tsltsl (n_tsltsl),
        .n_tmerq  (n_tmerq),
        .n_tiorq  (n_tiorq),
        .n_twr    (n_twr),
        .n_trd    (n_trd),
        .ta       (ta),
        .td       (td),
        .tdir     (tdir),
        .tsnd     (tsnd),
        .n_led    (n_led),
        .button   (button),
        .dip_sw   (dip_sw),
        .twait    (twait),
        .tint     (tint),
        .midi_out (midi_out),
        .midi_in  (midi_in)
    );

    typedef struct {
        logic [15:0] addr;
        logic        slt;
        logic        exp_dir;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic add_vec(input logic [15:0] a, input logic s, input logic d, input logic [7:0] x);
        vecs[nvec].addr     = a;
        vecs[nvec].slt      = s;
        vecs[nvec].exp_dir  = d;
        vecs[nvec].exp_data = x;
        nvec++;
    endtask

    // Drives one memory read; waits on tdir are bounded to 3 edges.
    task automatic do_read(input logic [15:0] addr, input logic slt, input logic exp_dir,
                           input logic [7:0] exp_data);
        int   lat;
        logic seen;
        string nm;
        nm = $sformatf("rd%04h_s%0d", addr, slt);
        @(negedge tclock);
        ta = addr; n_tsltsl = slt; n_tmerq = 1'b0;
        repeat (6) @(negedge tclock);
        n_trd = 1'b0;
        lat = 0;
        if (exp_dir) begin
            while (tdir !== 1'b1 && lat < 3) begin
                @(posedge tclock); #1; lat++;
            end
            chk({nm, "_tdir_rise"}, int'(tdir), 1);
            chk({nm, "_data"}, int'(td), int'(exp_data));
`ifndef TANGCART_LED_PORT_EN
            chk({nm, "_actled"}, int'(n_led), 6'h3E);
`endif
            repeat (12 - lat) @(posedge tclock);
            #1;
            chk({nm, "_data_hold"}, int'(td), int'(exp_data));
            @(negedge tclock);
            n_trd = 1'b1;
            lat = 0;
            while (tdir !== 1'b0 && lat < 3) begin
                @(posedge tclock); #1; lat++;
            end
            chk({nm, "_tdir_fall"}, int'(tdir), 0);
        end else begin
            seen = 1'b0;
            repeat (12) begin
                @(posedge tclock); #1;
                if (tdir !== 1'b0) seen = 1'b1;
            end
            chk({nm, "_nodrive"}, int'(seen), 0);
            @(negedge tclock);
            n_trd = 1'b1;
        end
        @(negedge tclock);
        n_tmerq = 1'b1; n_tsltsl = 1'b1;
        repeat (4) @(negedge tclock);
    endtask

`ifdef TANGCART_LED_PORT_EN
    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        @(negedge tclock);
        ta = {8'h00, port}; tb_data = data; tb_drv = 1'b1; n_tiorq = 1'b0;
        repeat (2) @(negedge tclock);
        n_twr = 1'b0;
        repeat (6) @(negedge tclock);
        n_twr = 1'b1;
        @(negedge tclock);
        n_tiorq = 1'b1; tb_drv = 1'b0;
        repeat (4) @(negedge tclock);
    endtask
`endif

    initial begin
        int lat;
        n_treset = 1'b0; n_tsltsl = 1'b1; n_tmerq = 1'b1; n_tiorq = 1'b1;
        n_twr = 1'b1; n_trd = 1'b1; ta = 16'h0000; midi_in = 1'b1;
        button = 2'b00; dip_sw = 7'h00; tb_drv = 1'b0; tb_data = 8'h00;

        add_vec(16'h4000, 1'b0, 1'b1, 8'h41);
        add_vec(16'h4001, 1'b0, 1'b1, 8'h42);
        add_vec(16'h4002, 1'b0, 1'b1, 8'h10);
        add_vec(16'h4003, 1'b0, 1'b1, 8'h40);
        for (int i = 4; i < 16; i++) add_vec(16'h4000 + 16'(i), 1'b0, 1'b1, 8'h00);
        add_vec(16'h4010, 1'b0, 1'b1, 8'h18);
        add_vec(16'h4011, 1'b0, 1'b1, 8'hFE);
        add_vec(16'h4012, 1'b0, 1'b1, 8'hFF);
        add_vec(16'h40FF, 1'b0, 1'b1, 8'hFF);
        add_vec(16'h7F00, 1'b0, 1'b1, 8'h41);
        add_vec(16'h8000, 1'b0, 1'b0, 8'h00);
        add_vec(16'h0000, 1'b0, 1'b0, 8'h00);
        add_vec(16'h4000, 1'b1, 1'b0, 8'h00);

        repeat (1000) @(posedge tclock);
        @(negedge tclock);
        n_treset = 1'b1;
        repeat (100) @(posedge tclock);
        #1;
        chk("rst_tdir", int'(tdir), 0);
        chk("rst_nled", int'(n_led), 6'h3F);
        chk("rst_tsnd", int'(tsnd), 0);
        chk("rst_twait", int'(twait), 0);
        chk("rst_tint", int'(tint), 0);
        chk("rst_midi", int'(midi_out), 1);

        for (int i = 0; i < nvec; i++)
            do_read(vecs[i].addr, vecs[i].slt, vecs[i].exp_dir, vecs[i].exp_data);

        // Memory read with a concurrent I/O request: memory path still serves data.
        @(negedge tclock);
        n_tiorq = 1'b0;
        do_read(16'h4002, 1'b0, 1'b1, 8'h10);
        n_tiorq = 1'b1;

        // Address change while the read strobe is held.
        @(negedge tclock);
        ta = 16'h4000; n_tsltsl = 1'b0; n_tmerq = 1'b0;
        repeat (6) @(negedge tclock);
        n_trd = 1'b0;
        repeat (3) @(posedge tclock);
        #1;
        chk("midrd_first", int'(td), 8'h41);
        @(negedge tclock);
        ta = 16'h4011;
        repeat (3) @(posedge tclock);
        #1;
        chk("midrd_change", int'(td), 8'hFE);

        // Reset asserted mid-read.
        @(negedge tclock);
        ta = 16'h4000;
        repeat (3) @(posedge tclock);
        #1;
        chk("rstrd_pre", int'(tdir), 1);
        @(negedge tclock);
        n_treset = 1'b0;
        @(posedge tclock);
        #1;
        chk("rstrd_tdir", int'(tdir), 0);
        @(negedge tclock);
        n_trd = 1'b1; n_tmerq = 1'b1; n_tsltsl = 1'b1;
        repeat (3) @(negedge tclock);
        n_treset = 1'b1;
        repeat (5) @(negedge tclock);
        do_read(16'h4001, 1'b0, 1'b1, 8'h42);

`ifdef TANGCART_LED_PORT_EN
        io_write(8'h10, 8'h05);
        chk("led_port10", int'(n_led), 6'h3A);
        io_write(8'h11, 8'h3F);
        chk("led_port11", int'(n_led), 6'h3A);
        io_write(8'h10, 8'h21);
        chk("led_port10b", int'(n_led), 6'h1E);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
